// File: rtl/inc_pipe_pkg.sv
// Shared constants and stage record for the inc_pipe two-stage incrementer.
// INC_PIPE_SAT_EN selects saturating increments and the ovf flag.
package inc_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] x;
        logic [DEFAULT_WIDTH-1:0] y;
        logic [DEFAULT_WIDTH-1:0] z;
    } stage_t;

endpackage

// File: rtl/inc_pipe_stage.sv
// One valid/ready register slice: forwards a pass-through lane and registers val+1.
// INC_PIPE_SAT_EN makes the increment saturate at all-ones and tracks overflow.
module inc_stage
    import inc_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PW    = DEFAULT_WIDTH
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_pass,
    input  logic [WIDTH-1:0] in_val,
`ifdef INC_PIPE_SAT_EN
    input  logic             in_ovf,
    output logic             out_ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_pass,
    output logic [WIDTH-1:0] out_inc
);

    logic             advance;
    logic [WIDTH-1:0] inc_val;
`ifdef INC_PIPE_SAT_EN
    logic             sat;
`endif

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        inc_val = in_val + WIDTH'(1);
`ifdef INC_PIPE_SAT_EN
        sat = &in_val;
        if (sat) begin
            inc_val = in_val;
        end
`endif
    end

    // Data only loads with a valid sample so a drained slice keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pass  <= '0;
            out_inc   <= '0;
`ifdef INC_PIPE_SAT_EN
            out_ovf   <= 1'b0;
`endif
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_pass <= in_pass;
                out_inc  <= inc_val;
`ifdef INC_PIPE_SAT_EN
                out_ovf  <= in_ovf || sat;
`endif
            end
        end
    end

endmodule

// File: rtl/inc_pipe.sv
// Two-stage pipeline producing (x, x+1, x+2) with valid/ready handshakes and a sample counter.
// Define INC_PIPE_SAT_EN for saturating arithmetic and the ovf output.
module inc_pipe
    import inc_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
`ifdef INC_PIPE_SAT_EN
    output logic             ovf,
`endif
    output logic [31:0]      count,
    output logic             busy
);

    logic               s1_valid;
    logic               s1_in_ready;
    logic               s2_in_ready;
    logic [WIDTH-1:0]   s1_x;
    logic [WIDTH-1:0]   s1_y;
    logic [2*WIDTH-1:0] s2_pass;
`ifdef INC_PIPE_SAT_EN
    logic               s1_ovf;
`endif

    assign in_ready = s1_in_ready && !reset;
    assign busy     = s1_valid || out_valid;
    assign out_x    = s2_pass[2*WIDTH-1:WIDTH];
    assign out_y    = s2_pass[WIDTH-1:0];

    // S1 holds x and y; S2 carries {x, y} through and adds z.
    inc_stage #(.WIDTH(WIDTH), .PW(WIDTH)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (s1_in_ready),
        .in_pass   (in_x),
        .in_val    (in_x),
`ifdef INC_PIPE_SAT_EN
        .in_ovf    (1'b0),
        .out_ovf   (s1_ovf),
`endif
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_pass  (s1_x),
        .out_inc   (s1_y)
    );

    inc_stage #(.WIDTH(WIDTH), .PW(2*WIDTH)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_pass   ({s1_x, s1_y}),
        .in_val    (s1_y),
`ifdef INC_PIPE_SAT_EN
        .in_ovf    (s1_ovf),
        .out_ovf   (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pass  (s2_pass),
        .out_inc   (out_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (in_valid && in_ready) begin
            count <= count + 32'd1;
        end
    end

endmodule
